// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Target side of the processor data-memory interface. Holds a word-organised
//   store, answers mem_read / mem_write after a fixed LATENCY, and flags
//   illegal requests (misaligned, out of range, or read and write together).
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-high reset
//     mem_read   in   read request, held until mem_ready
//     mem_write  in   write request, held until mem_ready
//     mem_addr   in   byte address
//     mem_wdata  in   write data
//     mem_rdata  out  registered read data, held until the next good read
//     mem_ready  out  one-cycle completion strobe
//     mem_err    out  error flag, meaningful only while mem_ready=1
//     mem_busy   out  high while a request is in flight
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a request; the only state that samples inputs
//   WAIT   | request latched, latency counter running down to zero
//   DONE   | mem_ready strobe cycle, then back to IDLE
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  mem_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic                    illegal_q, illegal_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    mem_we;

  logic [WORD_WIDTH-1:0]   mem_q [DEPTH];

  logic                    misaligned;
  logic                    out_of_range;
  logic                    both_ops;
  logic                    req_illegal;

  // Any address bit above the word-index field means the access falls
  // outside the implemented store.
  assign misaligned   = (mem_addr[1:0] != 2'b00);
  assign out_of_range = ((mem_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign both_ops     = mem_read & mem_write;
  assign req_illegal  = misaligned | out_of_range | both_ops;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    illegal_d = illegal_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_read | mem_write) begin
          state_d   = S_WAIT;
          cnt_d     = CNT_LOAD;
          op_wr_d   = mem_write;
          illegal_d = req_illegal;
          idx_d     = mem_addr[DEPTH_LOG2+1:2];
          wdata_d   = mem_wdata;
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Storage and mem_rdata are updated on the edge that enters DONE,
          // so the data is already stable during the mem_ready cycle.
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = illegal_q;
          if (!illegal_q) begin
            if (op_wr_q) begin
              mem_we = 1'b1;
            end else begin
              rdata_d = mem_q[idx_q];
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_wr_q   <= 1'b0;
      illegal_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      illegal_q <= illegal_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      if (mem_we) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Instance a uses LATENCY=2,
//   instance b uses LATENCY=1; both share reset, address and write data but
//   have independent read/write request lines.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_err, a_busy;
  logic        b_ready, b_err, b_busy;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.WORD_WIDTH(32), .DEPTH_LOG2(8), .LATENCY(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (a_read),
    .mem_write (a_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (a_rdata),
    .mem_ready (a_ready),
    .mem_err   (a_err),
    .mem_busy  (a_busy)
  );

  data_mem_responder #(.WORD_WIDTH(32), .DEPTH_LOG2(8), .LATENCY(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (b_read),
    .mem_write (b_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (b_rdata),
    .mem_ready (b_ready),
    .mem_err   (b_err),
    .mem_busy  (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance a (sel=0) or b (sel=1). Inputs are
  // applied just after an edge; the next edge is the accept edge E0. With
  // mutate set, mem_addr/mem_wdata are changed right after E0.
  task automatic txn(input string tag, input bit sel, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd, input bit mutate,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    lat       = 0;
    mem_addr  = addr;
    mem_wdata = wd;
    if (sel) begin b_read = rd; b_write = wr; end
    else     begin a_read = rd; a_write = wr; end
    @(posedge clk); #1;
    check({tag, ".busy"}, {31'd0, sel ? b_busy : a_busy}, 32'd1);
    if (mutate) begin
      mem_addr  = addr + 32'd4;
      mem_wdata = ~wd;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (sel ? b_ready : a_ready) begin
        lat = n;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'd0, sel ? b_err : a_err}, {31'd0, exp_err});
    check({tag, ".rdata"}, sel ? b_rdata : a_rdata, exp_rdata);
    a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    @(posedge clk); #1;
    check({tag, ".ready_drop"}, {31'd0, sel ? b_ready : a_ready}, 32'd0);
    check({tag, ".idle"}, {31'd0, sel ? b_busy : a_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.a_rdata", a_rdata, 32'd0);
    check("rst.a_ready", {31'd0, a_ready}, 32'd0);
    check("rst.a_err",   {31'd0, a_err},   32'd0);
    check("rst.a_busy",  {31'd0, a_busy},  32'd0);
    check("rst.b_rdata", b_rdata, 32'd0);
    check("rst.b_busy",  {31'd0, b_busy},  32'd0);

    // Instance a, LATENCY=2.
    txn("rd10",     0, 1, 0, 32'h0000_0010, 32'h0, 0, 2, 0, 32'h0000_0000);
    txn("wr40",     0, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 2, 0, 32'h0000_0000);
    txn("rd40",     0, 1, 0, 32'h0000_0040, 32'h0, 0, 2, 0, 32'hDEAD_BEEF);
    txn("rd44",     0, 1, 0, 32'h0000_0044, 32'h0, 0, 2, 0, 32'h0000_0000);
    txn("rd40b",    0, 1, 0, 32'h0000_0040, 32'h0, 0, 2, 0, 32'hDEAD_BEEF);
    txn("rd42mis",  0, 1, 0, 32'h0000_0042, 32'h0, 0, 2, 1, 32'hDEAD_BEEF);
    txn("rd400oor", 0, 1, 0, 32'h0000_0400, 32'h0, 0, 2, 1, 32'hDEAD_BEEF);
    txn("rd40c",    0, 1, 0, 32'h0000_0040, 32'h0, 0, 2, 0, 32'hDEAD_BEEF);
    txn("rdwr40",   0, 1, 1, 32'h0000_0040, 32'h1234_5678, 0, 2, 1, 32'hDEAD_BEEF);
    txn("rd44b",    0, 1, 0, 32'h0000_0044, 32'h0, 0, 2, 0, 32'h0000_0000);
    txn("rd40d",    0, 1, 0, 32'h0000_0040, 32'h0, 0, 2, 0, 32'hDEAD_BEEF);
    txn("wr8mut",   0, 0, 1, 32'h0000_0008, 32'hA5A5_A5A5, 1, 2, 0, 32'hDEAD_BEEF);
    txn("rdC",      0, 1, 0, 32'h0000_000C, 32'h0, 0, 2, 0, 32'h0000_0000);
    txn("rd8",      0, 1, 0, 32'h0000_0008, 32'h0, 0, 2, 0, 32'hA5A5_A5A5);

    // Instance b, LATENCY=1.
    txn("b.wr8mut", 1, 0, 1, 32'h0000_0008, 32'hA5A5_A5A5, 1, 1, 0, 32'h0000_0000);
    txn("b.rdC",    1, 1, 0, 32'h0000_000C, 32'h0, 0, 1, 0, 32'h0000_0000);
    txn("b.rd8",    1, 1, 0, 32'h0000_0008, 32'h0, 0, 1, 0, 32'hA5A5_A5A5);

    // Reset during WAIT of a write on instance a (a_rdata is A5A5_A5A5 here).
    mem_addr  = 32'h0000_000C;
    mem_wdata = 32'h0BAD_F00D;
    a_write   = 1'b1;
    @(posedge clk); #1;
    check("abort.busy_pre", {31'd0, a_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort.busy",  {31'd0, a_busy},  32'd0);
    check("abort.ready", {31'd0, a_ready}, 32'd0);
    check("abort.rdata", a_rdata, 32'd0);
    check("abort.b_rdata", b_rdata, 32'd0);
    a_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort.idle_busy", {31'd0, a_busy}, 32'd0);
    end
    txn("post.rdC",  0, 1, 0, 32'h0000_000C, 32'h0, 0, 2, 0, 32'h0000_0000);
    txn("post.rd40", 0, 1, 0, 32'h0000_0040, 32'h0, 0, 2, 0, 32'h0000_0000);
    txn("post.b.rd8", 1, 1, 0, 32'h0000_0008, 32'h0, 0, 1, 0, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
